i2s_tx_param: RTL and testbench

I2S_TX_PARAM -- requirements
Module: i2s_tx_param

---
 rtl/i2s_pkg.sv | 26 ++
 rtl/i2s_clk_div.sv | 39 +++
 rtl/i2s_tx_param.sv | 183 ++++++++++++++++++
 tb/tb_i2s_tx_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmitter: justification modes, default
// geometry and a counter-width helper used by the divider and bit counter.
package i2s_pkg;

   localparam int JUSTIFY_I2S  = 0;   // Philips I2S, MSB one SCLK after LRCLK edge
   localparam int JUSTIFY_LEFT = 1;   // left-justified, MSB coincident with LRCLK edge

   localparam int DEF_SAMPLE_BITS = 16;
   localparam int DEF_SLOT_BITS   = 32;
   localparam int DEF_SCLK_HALF   = 4;
   localparam int DEF_MCLK_HALF   = 1;
   localparam int DEF_JUSTIFY     = JUSTIFY_I2S;

   // Width of a counter that must hold 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Half-period clock divider: produces a divided clock level and a strobe
// that is high in the i_Clk cycle whose rising edge takes the level 1->0.
module i2s_clk_div
   import i2s_pkg::*;
#(
   parameter int HALF = 1
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   output logic o_clk,
   output logic o_fall
);

   localparam int               CNT_W = cnt_width(HALF);
   localparam logic [CNT_W-1:0] TC    = CNT_W'(HALF - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             clk_r;
   logic             tc_s;

   assign tc_s = (cnt_r == TC);

   // Count i_Clk cycles of the half-period and toggle the level at terminal count
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         cnt_r <= '0;
         clk_r <= 1'b0;
      end else if (tc_s) begin
         cnt_r <= '0;
         clk_r <= ~clk_r;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign o_clk  = clk_r;
   assign o_fall = tc_s & clk_r;

endmodule

// File: rtl/i2s_tx_param.sv
// Parameterised I2S master transmitter with a one-entry sample-pair buffer.
// LRCLK and SDIN change only together with the SCLK falling edge; a frame
// that starts with no fresh pair repeats the previous one and flags underrun.
module i2s_tx_param
   import i2s_pkg::*;
#(
   parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
   parameter int SLOT_BITS   = DEF_SLOT_BITS,
   parameter int SCLK_HALF   = DEF_SCLK_HALF,
   parameter int MCLK_HALF   = DEF_MCLK_HALF,
   parameter int JUSTIFY     = DEF_JUSTIFY
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_n,
   input  logic [SAMPLE_BITS-1:0] i_Left,
   input  logic [SAMPLE_BITS-1:0] i_Right,
   input  logic                   i_Valid,
   output logic                   o_Ready,
   output logic                   o_MCLK,
   output logic                   o_SCLK,
   output logic                   o_LRCLK,
   output logic                   o_SDIN,
   output logic                   o_Underrun
);

   localparam int             FRAME_BITS = 2 * SLOT_BITS;
   localparam int             B_W        = cnt_width(FRAME_BITS);
   localparam logic [B_W-1:0] B_LAST     = B_W'(FRAME_BITS - 1);
   localparam logic [B_W-1:0] B_SLOT     = B_W'(SLOT_BITS);
   localparam logic [B_W-1:0] B_SAMPLE   = B_W'(SAMPLE_BITS);

   logic                   sclk_s;
   logic                   sclk_fall_s;
   logic                   mclk_s;
   logic                   mclk_fall_unused_s;

   logic [B_W-1:0]         b_r;
   logic                   lrclk_r;
   logic                   sdin_r;
   logic                   underrun_r;
   logic                   full_r;
   logic [SAMPLE_BITS-1:0] buf_left_r;
   logic [SAMPLE_BITS-1:0] buf_right_r;
   logic [SAMPLE_BITS-1:0] left_r;
   logic [SAMPLE_BITS-1:0] right_r;

   logic                   frame_start_s;
   logic                   accept_s;
   logic [B_W-1:0]         b_next_s;
   logic [B_W-1:0]         pos_s;
   logic [B_W-1:0]         sh_s;
   logic [SAMPLE_BITS-1:0] left_next_s;
   logic [SAMPLE_BITS-1:0] right_next_s;
   logic [SAMPLE_BITS-1:0] sample_s;
   logic [SAMPLE_BITS-1:0] shifted_s;
   logic                   lrclk_next_s;
   logic                   sdin_next_s;

   i2s_clk_div #(.HALF(SCLK_HALF)) u_sclk_div (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .o_clk   (sclk_s),
      .o_fall  (sclk_fall_s)
   );

   // MCLK runs free; its falling strobe has no consumer
   i2s_clk_div #(.HALF(MCLK_HALF)) u_mclk_div (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .o_clk   (mclk_s),
      .o_fall  (mclk_fall_unused_s)
   );

   assign frame_start_s = sclk_fall_s & (b_r == B_LAST);
   assign accept_s      = i_Valid & ~full_r;

   // Next bit index, the sample pair in force for it, and the bit to present
   always_comb begin
      b_next_s     = b_r;
      pos_s        = '0;
      sh_s         = '0;
      left_next_s  = left_r;
      right_next_s = right_r;
      sample_s     = '0;
      shifted_s    = '0;
      lrclk_next_s = 1'b0;
      sdin_next_s  = 1'b0;

      if (b_r == B_LAST) begin
         b_next_s = '0;
      end else begin
         b_next_s = b_r + B_W'(1);
      end

      // A new frame takes the buffered pair if there is one, else repeats
      if (frame_start_s && full_r) begin
         left_next_s  = buf_left_r;
         right_next_s = buf_right_r;
      end else begin
         left_next_s  = left_r;
         right_next_s = right_r;
      end

      if (b_next_s < B_SLOT) begin
         lrclk_next_s = 1'b0;
         pos_s        = b_next_s;
         sample_s     = left_next_s;
      end else begin
         lrclk_next_s = 1'b1;
         pos_s        = b_next_s - B_SLOT;
         sample_s     = right_next_s;
      end

      if (JUSTIFY == JUSTIFY_LEFT) begin
         if (pos_s < B_SAMPLE) begin
            sh_s        = B_SAMPLE - B_W'(1) - pos_s;
            shifted_s   = sample_s >> sh_s;
            sdin_next_s = shifted_s[0];
         end else begin
            sdin_next_s = 1'b0;
         end
      end else begin
         if ((pos_s >= B_W'(1)) && (pos_s <= B_SAMPLE)) begin
            sh_s        = B_SAMPLE - pos_s;
            shifted_s   = sample_s >> sh_s;
            sdin_next_s = shifted_s[0];
         end else begin
            sdin_next_s = 1'b0;
         end
      end
   end

   // Step the bit index and launch LRCLK/SDIN with each SCLK falling edge
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         b_r     <= B_LAST;
         lrclk_r <= 1'b0;
         sdin_r  <= 1'b0;
      end else if (sclk_fall_s) begin
         b_r     <= b_next_s;
         lrclk_r <= lrclk_next_s;
         sdin_r  <= sdin_next_s;
      end
   end

   // Latch the pair being serialised at every frame start
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         left_r  <= '0;
         right_r <= '0;
      end else if (frame_start_s) begin
         left_r  <= left_next_s;
         right_r <= right_next_s;
      end
   end

   // Holding buffer handshake and one-cycle underrun flag
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         full_r      <= 1'b0;
         buf_left_r  <= '0;
         buf_right_r <= '0;
         underrun_r  <= 1'b0;
      end else begin
         underrun_r <= frame_start_s & ~full_r;
         if (frame_start_s && full_r) begin
            full_r <= 1'b0;
         end else if (accept_s) begin
            full_r      <= 1'b1;
            buf_left_r  <= i_Left;
            buf_right_r <= i_Right;
         end
      end
   end

   assign o_Ready    = ~full_r;
   assign o_MCLK     = mclk_s;
   assign o_SCLK     = sclk_s;
   assign o_LRCLK    = lrclk_r;
   assign o_SDIN     = sdin_r;
   assign o_Underrun = underrun_r;

endmodule

// File: tb/tb_i2s_tx_param.sv
// Bench for i2s_tx_param: a default Philips-mode instance and a 24-bit
// left-justified instance. Serial frames are decoded from the pins on the
// falling i_Clk edge and compared with hand-computed bit streams.
module tb_i2s_tx_param;

   logic i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   // Default instance
   logic        rst0_n, v0, rdy0, mclk0, sclk0, lr0, sd0, und0;
   logic [15:0] l0, r0;
   // 24-bit left-justified instance
   logic        rst1_n, v1, rdy1, mclk1, sclk1, lr1, sd1, und1;
   logic [23:0] l1, r1;

   i2s_tx_param dut0 (
      .i_Clk(i_Clk), .i_Rst_n(rst0_n), .i_Left(l0), .i_Right(r0), .i_Valid(v0),
      .o_Ready(rdy0), .o_MCLK(mclk0), .o_SCLK(sclk0), .o_LRCLK(lr0),
      .o_SDIN(sd0), .o_Underrun(und0)
   );

   i2s_tx_param #(.SAMPLE_BITS(24), .SLOT_BITS(24), .JUSTIFY(1)) dut1 (
      .i_Clk(i_Clk), .i_Rst_n(rst1_n), .i_Left(l1), .i_Right(r1), .i_Valid(v1),
      .o_Ready(rdy1), .o_MCLK(mclk1), .o_SCLK(sclk1), .o_LRCLK(lr1),
      .o_SDIN(sd1), .o_Underrun(und1)
   );

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic [31:0] exp_l;   // left slot stream, p=0 in bit 31
      logic [31:0] exp_r;
   } vec_t;

   typedef struct {
      logic [63:0] lr;
      logic [63:0] sd;
      logic        ust;     // underrun seen in the frame-start cycle
      int          un;      // cycles with underrun high during the frame
      int          fsc;     // cycle number of the frame start
   } frame_t;

   vec_t   vecs[3];
   frame_t q0[$];
   frame_t q1[$];

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          bb[2];
   logic        prev[2];
   logic [63:0] slr[2];
   logic [63:0] ssd[2];
   logic        ust[2];
   int          un[2];
   int          fsc[2];
   logic        fs_flag[2];

   localparam logic [63:0] LR16 = 64'h00000000_FFFFFFFF;
   localparam logic [63:0] LR24 = 64'h00000000_00FFFFFF;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Decode one instance's pins at this sample point
   task automatic mon(input int d, input logic rst, input logic sclk, input logic lr,
                      input logic sd, input logic und, input int last);
      frame_t f;
      fs_flag[d] = 1'b0;
      if (!rst) begin
         bb[d] = last; prev[d] = 1'b0; slr[d] = '0; ssd[d] = '0;
         ust[d] = 1'b0; un[d] = 0;
      end else begin
         if (prev[d] && !sclk) begin
            bb[d] = (bb[d] == last) ? 0 : bb[d] + 1;
            if (bb[d] == 0) begin
               slr[d] = '0; ssd[d] = '0; un[d] = 0; ust[d] = und;
               fs_flag[d] = 1'b1; fsc[d] = cyc;
            end
            slr[d] = {slr[d][62:0], lr};
            ssd[d] = {ssd[d][62:0], sd};
         end
         if (und) un[d]++;
         if (prev[d] && !sclk && bb[d] == last) begin
            f.lr = slr[d]; f.sd = ssd[d]; f.ust = ust[d]; f.un = un[d]; f.fsc = fsc[d];
            if (d == 0) q0.push_back(f);
            else        q1.push_back(f);
         end
         prev[d] = sclk;
      end
   endtask

   task automatic tick();
      @(negedge i_Clk);
      cyc++;
      mon(0, rst0_n, sclk0, lr0, sd0, und0, 63);
      mon(1, rst1_n, sclk1, lr1, sd1, und1, 47);
   endtask

   function automatic frame_t fr(input int d, input int k);
      frame_t f;
      f.lr = '0; f.sd = '0; f.ust = 1'b0; f.un = -1; f.fsc = -1;
      if (d == 0 && k < q0.size()) f = q0[k];
      else if (d == 1 && k < q1.size()) f = q1[k];
      return f;
   endfunction

   task automatic chk_frame(input string nm, input int d, input int k, input logic [63:0] elr,
                            input logic [63:0] esd, input logic eust, input int eun);
      frame_t f;
      f = fr(d, k);
      chk({nm, "_lrclk"}, f.lr, elr);
      chk({nm, "_sdin"}, f.sd, esd);
      chk({nm, "_und_start"}, {63'd0, f.ust}, {63'd0, eust});
      chk({nm, "_und_cycles"}, 64'(f.un), 64'(eun));
   endtask

   task automatic wait_frames(input int d, input int cnt);
      int n;
      n = 0;
      while (((d == 0) ? q0.size() : q1.size()) < cnt && n < 20000) begin
         tick(); n++;
      end
      chk($sformatf("frames_ready_d%0d_%0d", d, cnt),
          {63'd0, (((d == 0) ? q0.size() : q1.size()) >= cnt)}, 64'd1);
   endtask

   task automatic wait_fs(input int d);
      int n;
      n = 0;
      do begin tick(); n++; end while (!fs_flag[d] && n < 2000);
      if (!fs_flag[d]) chk("frame_start_timeout", 64'd0, 64'd1);
   endtask

   // Offer a pair; junk data rides on i_Valid while o_Ready is low
   task automatic send(input logic [15:0] l, input logic [15:0] r);
      int n;
      n = 0;
      while (!rdy0 && n < 2000) begin
         l0 = 16'hDEAD; r0 = 16'hBEEF; v0 = 1'b1;
         tick(); n++;
      end
      if (!rdy0) chk("send_ready_timeout", 64'd0, 64'd1);
      l0 = l; r0 = r; v0 = 1'b1;
      tick();
      v0 = 1'b0;
   endtask

   initial begin
      int base, rel, acc, n;
      vecs[0] = '{l: 16'hA5C3, r: 16'h0F01, exp_l: 32'h52E18000, exp_r: 32'h07808000};
      vecs[1] = '{l: 16'hFFFF, r: 16'h0000, exp_l: 32'h7FFF8000, exp_r: 32'h00000000};
      vecs[2] = '{l: 16'h8001, r: 16'h7FFE, exp_l: 32'h40008000, exp_r: 32'h3FFF0000};

      rst0_n = 1'b0; rst1_n = 1'b0;
      l0 = vecs[0].l; r0 = vecs[0].r; v0 = 1'b1;
      l1 = 24'h800001; r1 = 24'hC00003; v1 = 1'b1;
      tick();

      // Reset state
      chk("rst_mclk", {63'd0, mclk0}, 64'd0);
      chk("rst_sclk", {63'd0, sclk0}, 64'd0);
      chk("rst_lrclk", {63'd0, lr0}, 64'd0);
      chk("rst_sdin", {63'd0, sd0}, 64'd0);
      chk("rst_underrun", {63'd0, und0}, 64'd0);
      chk("rst_ready", {63'd0, rdy0}, 64'd1);

      // Release with the first pair already offered
      rst0_n = 1'b1; rst1_n = 1'b1; rel = cyc;
      tick();
      v0 = 1'b0; v1 = 1'b0;
      send(vecs[1].l, vecs[1].r);
      send(vecs[2].l, vecs[2].r);
      wait_frames(0, 4);

      chk("first_fs_cycle", 64'(fr(0, 0).fsc - rel), 64'd8);
      chk("frame_period", 64'(fr(0, 1).fsc - fr(0, 0).fsc), 64'd512);
      for (int k = 0; k < 3; k++)
         chk_frame($sformatf("vec%0d", k), 0, k, LR16, {vecs[k].exp_l, vecs[k].exp_r}, 1'b0, 0);
      chk_frame("repeat_underrun", 0, 3, LR16, {vecs[2].exp_l, vecs[2].exp_r}, 1'b1, 1);

      // Continuous i_Valid: one accept per frame
      l0 = vecs[0].l; r0 = vecs[0].r; v0 = 1'b1;
      wait_fs(0);
      for (int i = 0; i < 2; i++) begin
         acc = 0; n = 0;
         do begin
            if (v0 && rdy0) acc++;
            tick(); n++;
         end while (!fs_flag[0] && n < 1000);
         chk($sformatf("accepts_interval%0d", i), 64'(acc), 64'd1);
         chk($sformatf("interval_len%0d", i), 64'(n), 64'd512);
      end
      v0 = 1'b0;

      // Offer exactly in the cycle whose edge starts an empty-buffer frame
      repeat (511) tick();
      chk("ready_before_fs", {63'd0, rdy0}, 64'd1);
      l0 = vecs[1].l; r0 = vecs[1].r; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      chk("fs_on_offer_edge", {63'd0, fs_flag[0]}, 64'd1);
      wait_frames(0, 9);
      for (int k = 4; k < 7; k++)
         chk_frame($sformatf("stream%0d", k), 0, k, LR16, {vecs[0].exp_l, vecs[0].exp_r}, 1'b0, 0);
      chk_frame("fs_accept_underrun", 0, 7, LR16, {vecs[0].exp_l, vecs[0].exp_r}, 1'b1, 1);
      chk_frame("fs_accept_next", 0, 8, LR16, {vecs[1].exp_l, vecs[1].exp_r}, 1'b0, 0);

      // Reset at b=20 of the left slot with a pair buffered
      wait_fs(0);
      send(vecs[2].l, vecs[2].r);
      n = 0;
      while (bb[0] != 20 && n < 2000) begin tick(); n++; end
      repeat (4) tick();
      chk("midrst_sclk_high", {63'd0, sclk0}, 64'd1);
      #1 rst0_n = 1'b0;
      #1;
      chk("midrst_mclk", {63'd0, mclk0}, 64'd0);
      chk("midrst_sclk", {63'd0, sclk0}, 64'd0);
      chk("midrst_lrclk", {63'd0, lr0}, 64'd0);
      chk("midrst_sdin", {63'd0, sd0}, 64'd0);
      chk("midrst_underrun", {63'd0, und0}, 64'd0);
      chk("midrst_ready", {63'd0, rdy0}, 64'd1);
      repeat (3) tick();
      rst0_n = 1'b1; rel = cyc; base = q0.size();
      wait_frames(0, base + 1);
      chk("post_rst_fs_cycle", 64'(fr(0, base).fsc - rel), 64'd8);
      chk_frame("post_rst_frame", 0, base, LR16, 64'd0, 1'b1, 1);

      // Left-justified 24-bit instance
      wait_frames(1, 2);
      chk("lj_first_fs_cycle", 64'(fr(1, 0).fsc), 64'd9);
      chk_frame("lj_frame0", 1, 0, LR24, 64'h0000_8000_01C0_0003, 1'b0, 0);
      chk("lj_frame_period", 64'(fr(1, 1).fsc - fr(1, 0).fsc), 64'd384);
      chk_frame("lj_repeat", 1, 1, LR24, 64'h0000_8000_01C0_0003, 1'b1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
